// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Holds the default widths, the zero-register constant, the buffered entry layout and the write-select encoding.
package wb_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  localparam logic [ADDR_W_DEF-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_PIPE = 2'd1,
    SEL_FIFO = 2'd2
  } wb_sel_e;

endpackage

// File: rtl/wb_late_fifo.sv
// Late-result buffer: {rd, data} storage, head/tail pointers, occupancy count and destination hit compare.
// The caller guarantees no push when full and no pop when empty.
module wb_late_fifo
  import wb_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] pushRd,
  input  logic [DATA_W-1:0] pushData,
  input  logic              pop,
  output logic [ADDR_W-1:0] headRd,
  output logic [DATA_W-1:0] headData,
  output logic              full,
  output logic              empty,
  input  logic [ADDR_W-1:0] chkA,
  input  logic [ADDR_W-1:0] chkB,
  output logic              hitA,
  output logic              hitB
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] rdMem   [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];
  logic [DEPTH-1:0]  validMem;
  logic [PTR_W-1:0]  headPtr;
  logic [PTR_W-1:0]  tailPtr;
  logic [CNT_W-1:0]  countQ;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      headPtr  <= '0;
      tailPtr  <= '0;
      countQ   <= '0;
      validMem <= '0;
    end else begin
      if (pop) begin
        validMem[headPtr] <= 1'b0;
        headPtr           <= headPtr + PTR_W'(1);
      end
      if (push) begin
        validMem[tailPtr] <= 1'b1;
        tailPtr           <= tailPtr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   countQ <= countQ + CNT_W'(1);
        2'b01:   countQ <= countQ - CNT_W'(1);
        default: countQ <= countQ;
      endcase
    end
  end

  // Payload needs no reset: validMem alone decides what is live.
  always_ff @(posedge clock) begin
    if (push) begin
      rdMem[tailPtr]   <= pushRd;
      dataMem[tailPtr] <= pushData;
    end
  end

  assign headRd   = rdMem[headPtr];
  assign headData = dataMem[headPtr];
  assign full     = (countQ == CNT_W'(DEPTH));
  assign empty    = (countQ == '0);

  always_comb begin
    hitA = 1'b0;
    hitB = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (validMem[i] && rdMem[i] == chkA) hitA = 1'b1;
      if (validMem[i] && rdMem[i] == chkB) hitB = 1'b1;
    end
    if (chkA == ADDR_W'(REG_ZERO)) hitA = 1'b0;
    if (chkB == ADDR_W'(REG_ZERO)) hitB = 1'b0;
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Shares the register-file write port between the in-order writeback stream and buffered late results.
// Stalls the pipeline only when the late FIFO is full or its head has waited STARVE_MAX cycles.
module wb_write_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              pipe_wen,
  input  logic [ADDR_W-1:0] pipe_rd,
  input  logic [DATA_W-1:0] pipe_data,
  input  logic              lat_valid,
  input  logic [ADDR_W-1:0] lat_rd,
  input  logic [DATA_W-1:0] lat_data,
  output logic              lat_ready,
  output logic              stall,
  input  logic [ADDR_W-1:0] chk_a,
  input  logic [ADDR_W-1:0] chk_b,
  output logic              hit_a,
  output logic              hit_b,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  localparam int ST_W = $clog2(STARVE_MAX + 1);

  logic              fifoFull;
  logic              fifoEmpty;
  logic [ADDR_W-1:0] headRd;
  logic [DATA_W-1:0] headData;
  logic              push;
  logic              pop;
  logic [ST_W-1:0]   starveCnt;
  wb_sel_e           sel;

  // Late handshake: a result transfers at the rising edge where lat_valid && lat_ready;
  // lat_ready depends only on pre-edge occupancy, so a same-cycle drain never frees a slot early.
  assign lat_ready = !fifoFull;
  assign push      = lat_valid && lat_ready && (lat_rd != ADDR_W'(REG_ZERO));
  assign stall     = fifoFull || (starveCnt == ST_W'(STARVE_MAX));
  assign pop       = (sel == SEL_FIFO);

  always_comb begin
    sel = SEL_NONE;
    if (stall)
      sel = SEL_FIFO;
    else if (pipe_wen && pipe_rd != ADDR_W'(REG_ZERO))
      sel = SEL_PIPE;
    else if (!fifoEmpty)
      sel = SEL_FIFO;
  end

  wb_late_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (push),
    .pushRd   (lat_rd),
    .pushData (lat_data),
    .pop      (pop),
    .headRd   (headRd),
    .headData (headData),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .chkA     (chk_a),
    .chkB     (chk_b),
    .hitA     (hit_a),
    .hitB     (hit_b)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      starveCnt <= '0;
    else if (fifoEmpty || pop)
      starveCnt <= '0;
    else if (starveCnt != ST_W'(STARVE_MAX))
      starveCnt <= starveCnt + ST_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= (sel != SEL_NONE);
      case (sel)
        SEL_PIPE: begin
          rf_waddr <= pipe_rd;
          rf_wdata <= pipe_data;
        end
        SEL_FIFO: begin
          rf_waddr <= headRd;
          rf_wdata <= headData;
        end
        default: begin
          rf_waddr <= rf_waddr;
          rf_wdata <= rf_wdata;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed vector table, reset-mid-traffic sequence, and random traffic
// checked against a queue-based reference model.
module tb_wb_write_arbiter;
  import wb_arb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 2;
  localparam int STARVE_MAX = 4;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          pipe_wen = 1'b0;
  logic [AW-1:0] pipe_rd = '0;
  logic [DW-1:0] pipe_data = '0;
  logic          lat_valid = 1'b0;
  logic [AW-1:0] lat_rd = '0;
  logic [DW-1:0] lat_data = '0;
  logic          lat_ready;
  logic          stall;
  logic [AW-1:0] chk_a = '0;
  logic [AW-1:0] chk_b = '0;
  logic          hit_a;
  logic          hit_b;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  wb_write_arbiter #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .pipe_wen(pipe_wen), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .lat_valid(lat_valid), .lat_rd(lat_rd), .lat_data(lat_data),
    .lat_ready(lat_ready), .stall(stall),
    .chk_a(chk_a), .chk_b(chk_b), .hit_a(hit_a), .hit_b(hit_b),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  // clock / reset
  always #5 clock = ~clock;

  typedef struct {
    logic          pw;
    logic [AW-1:0] prd;
    logic [DW-1:0] pdata;
    logic          lv;
    logic [AW-1:0] lrd;
    logic [DW-1:0] ldata;
    logic [AW-1:0] ca;
    logic [AW-1:0] cb;
    logic          eReady;
    logic          eStall;
    logic          eHa;
    logic          eHb;
    logic          eWe;
    logic [AW-1:0] eAddr;
    logic [DW-1:0] eData;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  wb_entry_t mq[$];
  int        mStarve = 0;

  function automatic vec_t mk(logic pw, logic [AW-1:0] prd, logic [DW-1:0] pdata,
                              logic lv, logic [AW-1:0] lrd, logic [DW-1:0] ldata,
                              logic [AW-1:0] ca, logic [AW-1:0] cb,
                              logic eReady, logic eStall, logic eHa, logic eHb,
                              logic eWe, logic [AW-1:0] eAddr, logic [DW-1:0] eData);
    vec_t v;
    v.pw = pw; v.prd = prd; v.pdata = pdata;
    v.lv = lv; v.lrd = lrd; v.ldata = ldata;
    v.ca = ca; v.cb = cb;
    v.eReady = eReady; v.eStall = eStall; v.eHa = eHa; v.eHb = eHb;
    v.eWe = eWe; v.eAddr = eAddr; v.eData = eData;
    return v;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // driver: present inputs, check combinational outputs mid-cycle, check registered outputs after the edge
  task automatic applyVec(input vec_t v, input string tag);
    pipe_wen = v.pw; pipe_rd = v.prd; pipe_data = v.pdata;
    lat_valid = v.lv; lat_rd = v.lrd; lat_data = v.ldata;
    chk_a = v.ca; chk_b = v.cb;
    @(negedge clock);
    check({tag, ".lat_ready"}, DW'(lat_ready), DW'(v.eReady));
    check({tag, ".stall"}, DW'(stall), DW'(v.eStall));
    check({tag, ".hit_a"}, DW'(hit_a), DW'(v.eHa));
    check({tag, ".hit_b"}, DW'(hit_b), DW'(v.eHb));
    @(posedge clock);
    #1;
    check({tag, ".rf_we"}, DW'(rf_we), DW'(v.eWe));
    if (v.eWe) begin
      check({tag, ".rf_waddr"}, DW'(rf_waddr), DW'(v.eAddr));
      check({tag, ".rf_wdata"}, rf_wdata, v.eData);
    end
  endtask

  task automatic driveIdle();
    pipe_wen = 1'b0; pipe_rd = '0; pipe_data = '0;
    lat_valid = 1'b0; lat_rd = '0; lat_data = '0;
  endtask

  // reference model: queue of pending results, port priority straight from the rules
  task automatic modelStep(input vec_t vin, output vec_t v);
    int        sz;
    bit        drained;
    wb_entry_t e;
    v = vin;
    sz = mq.size();
    drained = 1'b0;
    v.eReady = (sz < DEPTH);
    v.eStall = (sz == DEPTH) || (mStarve == STARVE_MAX);
    v.eHa = 1'b0;
    v.eHb = 1'b0;
    foreach (mq[i]) begin
      if (vin.ca != 0 && mq[i].rd == vin.ca) v.eHa = 1'b1;
      if (vin.cb != 0 && mq[i].rd == vin.cb) v.eHb = 1'b1;
    end
    v.eWe = 1'b1;
    if (v.eStall || (!(vin.pw && vin.prd != 0) && sz > 0)) begin
      e = mq.pop_front();
      v.eAddr = e.rd;
      v.eData = e.data;
      drained = 1'b1;
    end else if (vin.pw && vin.prd != 0) begin
      v.eAddr = vin.prd;
      v.eData = vin.pdata;
    end else begin
      v.eWe = 1'b0;
      v.eAddr = '0;
      v.eData = '0;
    end
    if (vin.lv && v.eReady && vin.lrd != 0) begin
      e.rd = vin.lrd;
      e.data = vin.ldata;
      mq.push_back(e);
    end
    if (sz == 0 || drained) mStarve = 0;
    else if (mStarve < STARVE_MAX) mStarve++;
  endtask

  vec_t tbl[17];

  initial begin
    vec_t v;
    vec_t r;

    // directed table, starting from reset: {pw,prd,pdata, lv,lrd,ldata, ca,cb, ready,stall,ha,hb, we,addr,data}
    tbl[0]  = mk(1, 3, 32'h11, 0, 0, 0,     0,  0, 1, 0, 0, 0, 1, 3, 32'h11);
    tbl[1]  = mk(0, 0, 0,      0, 0, 0,     3,  0, 1, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0,      1, 7, 32'hAA, 7, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0,      0, 0, 0,     7,  7, 1, 0, 1, 1, 1, 7, 32'hAA);
    tbl[4]  = mk(0, 0, 0,      0, 0, 0,     7,  0, 1, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 0, 32'h66, 1, 0, 32'h55, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0,      0, 0, 0,     0,  0, 1, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(1, 5, 32'h50, 1, 8, 32'h80, 8, 0, 1, 0, 0, 0, 1, 5, 32'h50);
    tbl[8]  = mk(1, 5, 32'h51, 1, 9, 32'h90, 8, 9, 1, 0, 1, 0, 1, 5, 32'h51);
    tbl[9]  = mk(1, 5, 32'h52, 1, 10, 32'hA0, 8, 9, 0, 1, 1, 1, 1, 8, 32'h80);
    tbl[10] = mk(1, 5, 32'h52, 0, 0, 0,     10, 9, 1, 0, 0, 1, 1, 5, 32'h52);
    tbl[11] = mk(1, 5, 32'h53, 0, 0, 0,     10, 9, 1, 0, 0, 1, 1, 5, 32'h53);
    tbl[12] = mk(1, 5, 32'h54, 0, 0, 0,     10, 9, 1, 0, 0, 1, 1, 5, 32'h54);
    tbl[13] = mk(1, 5, 32'h55, 0, 0, 0,     10, 9, 1, 0, 0, 1, 1, 5, 32'h55);
    tbl[14] = mk(1, 5, 32'h56, 0, 0, 0,     10, 9, 1, 1, 0, 1, 1, 9, 32'h90);
    tbl[15] = mk(1, 5, 32'h56, 0, 0, 0,     10, 9, 1, 0, 0, 0, 1, 5, 32'h56);
    tbl[16] = mk(0, 0, 0,      0, 0, 0,     10, 9, 1, 0, 0, 0, 0, 0, 0);

    // reset values
    #2;
    check("rst.rf_we", DW'(rf_we), 0);
    check("rst.rf_waddr", DW'(rf_waddr), 0);
    check("rst.rf_wdata", rf_wdata, 0);
    check("rst.lat_ready", DW'(lat_ready), 1);
    check("rst.stall", DW'(stall), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    for (int i = 0; i < 17; i++) applyVec(tbl[i], $sformatf("vec%0d", i));

    // reset while two late results are queued
    pipe_wen = 1'b1; pipe_rd = 5'd5; pipe_data = 32'h5A;
    lat_valid = 1'b1; lat_rd = 5'd11; lat_data = 32'hB1;
    chk_a = 5'd11; chk_b = 5'd12;
    @(posedge clock); #1;
    lat_rd = 5'd12; lat_data = 32'hB2;
    @(posedge clock); #1;
    driveIdle();
    check("mid.stall_full", DW'(stall), 1);
    check("mid.hit_a_pre", DW'(hit_a), 1);
    check("mid.hit_b_pre", DW'(hit_b), 1);
    #2;
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("mid.rf_we", DW'(rf_we), 0);
      check("mid.rf_waddr", DW'(rf_waddr), 0);
      check("mid.rf_wdata", rf_wdata, 0);
      check("mid.lat_ready", DW'(lat_ready), 1);
      check("mid.stall", DW'(stall), 0);
      check("mid.hit_a", DW'(hit_a), 0);
      check("mid.hit_b", DW'(hit_b), 0);
      @(posedge clock); #1;
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clock); #1;
      check("post.rf_we", DW'(rf_we), 0);
      check("post.hit_a", DW'(hit_a), 0);
    end

    // random traffic against the reference model
    mq.delete();
    mStarve = 0;
    for (int n = 0; n < 1500; n++) begin
      v.pw = ($urandom_range(0, 99) < 55);
      v.prd = AW'($urandom_range(0, 7));
      v.pdata = $urandom;
      v.lv = ($urandom_range(0, 99) < 40);
      v.lrd = AW'($urandom_range(0, 7));
      v.ldata = $urandom;
      v.ca = AW'($urandom_range(0, 7));
      v.cb = AW'($urandom_range(0, 7));
      modelStep(v, r);
      applyVec(r, $sformatf("rnd%0d", n));
    end

    driveIdle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
